sdram_chip_responder: RTL

//  Synthesizable SDR SDRAM device-side responder: decodes nRAS/nCAS/nWE commands, tracks per-bank open rows,

---
 rtl/sdram_chip_responder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_chip_responder.sv
// SDR SDRAM device-side responder: command decode, per-bank open rows, internal array, CAS-latency reads.
// Define SDRAM_RESP_CHECK_EN to build the sticky protocol checker (err) and per-bank tRCD counters.
module sdram_chip_responder #(
   parameter int unsigned ROW_BITS = 3,
   parameter int unsigned TRCD     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdram_cke,
   input  logic        sdram_ncs,
   input  logic        sdram_nras,
   input  logic        sdram_ncas,
   input  logic        sdram_nwe,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic        sdram_dqml,
   input  logic        sdram_dqmh,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic [1:0]  dq_oe,
   output logic        ready,
   output logic [12:0] mode_reg,
   output logic [15:0] refresh_cnt,
   output logic [3:0]  err
);

   localparam int unsigned AddrW = 2 + ROW_BITS + 9;
   localparam int unsigned Depth = 1 << AddrW;

   localparam logic [2:0] CmdAct = 3'b011;
   localparam logic [2:0] CmdRd  = 3'b101;
   localparam logic [2:0] CmdWr  = 3'b100;
   localparam logic [2:0] CmdPre = 3'b010;
   localparam logic [2:0] CmdRef = 3'b001;
   localparam logic [2:0] CmdMrs = 3'b000;

   typedef enum logic [2:0] {StWaitPre, StWaitRef1, StWaitRef2, StWaitMrs, StReady} init_state_e;

   init_state_e r_init_state, w_init_state_next;

   logic [3:0]          r_bank_active, w_bank_active_next;
   logic [ROW_BITS-1:0] r_bank_row [4];
   logic [12:0]         r_mode_reg;
   logic [15:0]         r_refresh_cnt;
   logic [15:0]         r_mem [Depth];

   // Two-stage read pipeline: stage 0 is loaded at the READ edge, stage 1 only serves CL3.
   logic        r_p0_vld, r_p0_cl3, r_p1_vld;
   logic [15:0] r_p0_data, r_p1_data;
   logic [1:0]  r_p0_mask, r_p1_mask;
   logic [15:0] r_dq_out;
   logic [1:0]  r_dq_oe;

   logic [2:0]       w_cmd;
   logic             w_cmd_en, w_ready, w_bank_open, w_cl3;
   logic             w_act, w_rd_req, w_wr_req, w_rw_req, w_pre, w_ref, w_mrs;
   logic             w_rd_ok, w_wr_ok;
   logic [AddrW-1:0] w_addr;
   logic [15:0]      w_rd_word;

   assign w_cmd       = {sdram_nras, sdram_ncas, sdram_nwe};
   assign w_cmd_en    = sdram_cke & ~sdram_ncs;
   assign w_ready     = (r_init_state == StReady);
   assign w_act       = w_cmd_en & w_ready & (w_cmd == CmdAct);
   assign w_rd_req    = w_cmd_en & w_ready & (w_cmd == CmdRd);
   assign w_wr_req    = w_cmd_en & w_ready & (w_cmd == CmdWr);
   assign w_rw_req    = w_rd_req | w_wr_req;
   assign w_pre       = w_cmd_en & (w_cmd == CmdPre);
   assign w_ref       = w_cmd_en & (w_cmd == CmdRef);
   assign w_mrs       = w_cmd_en & (w_cmd == CmdMrs) & ((r_init_state == StWaitMrs) | w_ready);
   assign w_bank_open = r_bank_active[sdram_ba];
   assign w_rd_ok     = w_rd_req & w_bank_open;
   assign w_wr_ok     = w_wr_req & w_bank_open;
   assign w_addr      = {sdram_ba, r_bank_row[sdram_ba], sdram_a[8:0]};
   assign w_rd_word   = r_mem[w_addr];
   assign w_cl3       = (r_mode_reg[6:4] == 3'd3);

   always_comb begin
      w_init_state_next = r_init_state;
      unique case (r_init_state)
         StWaitPre:  if (w_pre) w_init_state_next = StWaitRef1;
         StWaitRef1: if (w_ref) w_init_state_next = StWaitRef2;
         StWaitRef2: if (w_ref) w_init_state_next = StWaitMrs;
         StWaitMrs:  if (w_mrs) w_init_state_next = StReady;
         default:    w_init_state_next = r_init_state;
      endcase
   end

   always_comb begin
      w_bank_active_next = r_bank_active;
      if (w_act) w_bank_active_next[sdram_ba] = 1'b1;
      if ((w_rd_ok | w_wr_ok) & sdram_a[10]) w_bank_active_next[sdram_ba] = 1'b0;
      if (w_pre) begin
         if (sdram_a[10]) w_bank_active_next = '0;
         else             w_bank_active_next[sdram_ba] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_init_state  <= StWaitPre;
         r_bank_active <= '0;
         r_mode_reg    <= '0;
         r_refresh_cnt <= '0;
         r_p0_vld      <= 1'b0;
         r_p0_cl3      <= 1'b0;
         r_p0_data     <= '0;
         r_p0_mask     <= '0;
         r_p1_vld      <= 1'b0;
         r_p1_data     <= '0;
         r_p1_mask     <= '0;
         r_dq_out      <= '0;
         r_dq_oe       <= '0;
      end else begin
         r_init_state  <= w_init_state_next;
         r_bank_active <= w_bank_active_next;
         if (w_mrs) r_mode_reg <= sdram_a;
         if (w_ref) r_refresh_cnt <= r_refresh_cnt + 16'd1;
         if (sdram_cke) begin
            r_p0_vld <= w_rd_ok;
            if (w_rd_ok) begin
               r_p0_data <= w_rd_word;
               r_p0_mask <= {sdram_dqmh, sdram_dqml};
               r_p0_cl3  <= w_cl3;
            end
            r_p1_vld  <= r_p0_vld & r_p0_cl3;
            r_p1_data <= r_p0_data;
            r_p1_mask <= r_p0_mask;
            if (r_p0_vld && !r_p0_cl3) begin
               r_dq_out <= r_p0_data;
               r_dq_oe  <= ~r_p0_mask;
            end else if (r_p1_vld) begin
               r_dq_out <= r_p1_data;
               r_dq_oe  <= ~r_p1_mask;
            end else begin
               r_dq_oe  <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 4; b++) r_bank_row[b] <= '0;
      end else if (w_act) begin
         r_bank_row[sdram_ba] <= sdram_a[ROW_BITS-1:0];
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         if (!sdram_dqml) r_mem[w_addr][7:0]  <= dq_in[7:0];
         if (!sdram_dqmh) r_mem[w_addr][15:8] <= dq_in[15:8];
      end
   end

`ifdef SDRAM_RESP_CHECK_EN
   logic [7:0] r_trcd_cnt [4];
   logic [3:0] r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 4; b++) r_trcd_cnt[b] <= '0;
         r_err <= '0;
      end else if (sdram_cke) begin
         for (int b = 0; b < 4; b++) begin
            if (w_act && (sdram_ba == 2'(b))) r_trcd_cnt[b] <= 8'((TRCD > 0) ? TRCD - 1 : 0);
            else if (r_trcd_cnt[b] != 8'd0)   r_trcd_cnt[b] <= r_trcd_cnt[b] - 8'd1;
         end
         if (w_act && w_bank_open) r_err[0] <= 1'b1;
         if (w_rw_req && !w_bank_open) r_err[1] <= 1'b1;
         if (w_rw_req && w_bank_open && (r_trcd_cnt[sdram_ba] != 8'd0)) r_err[2] <= 1'b1;
         if (w_wr_req && (r_dq_oe != 2'b00)) r_err[3] <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_trcd;
   assign w_unused_trcd = ^TRCD;
   assign err = 4'h0;
`endif

   assign dq_out      = r_dq_out;
   assign dq_oe       = r_dq_oe;
   assign ready       = w_ready;
   assign mode_reg    = r_mode_reg;
   assign refresh_cnt = r_refresh_cnt;

endmodule
